// File: rtl/id_scoreboard.sv
// Pending-load scoreboard: per-register saturating load counters, RAW/WAW stall at decode.
// Optional macro ID_SCOREBOARD_CLR_BYPASS_EN lets same-cycle retires release the stall.
module id_scoreboard #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned NUM_CLR = 2,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned REG_AW  = 5
) (
    input  logic                        clk_i,
    input  logic                        reset_i,
    input  logic                        clk_en_i,
    input  logic                        iss_dav_i,
    input  logic                        iss_ack_i,
    input  logic [NUM_SRC-1:0]          iss_src_rd_i,
    input  logic [NUM_SRC*REG_AW-1:0]   iss_src_addr_i,
    input  logic                        iss_dst_tgt_i,
    input  logic [REG_AW-1:0]           iss_dst_addr_i,
    input  logic                        iss_is_load_i,
    input  logic [NUM_CLR-1:0]          clr_valid_i,
    input  logic [NUM_CLR*REG_AW-1:0]   clr_addr_i,
    input  logic                        flush_i,
    output logic                        stall_o,
    output logic                        busy_o,
    output logic [(1<<REG_AW)-2:0]      pend_vec_o,
    output logic                        err_o
);

    localparam int unsigned NREG    = 1 << REG_AW;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

    logic [CNT_W-1:0] cnt_q   [NREG];
    logic [CNT_W-1:0] cnt_nxt [NREG];
    logic [CNT_W-1:0] cnt_chk [NREG];
    logic [2:0]       dec_n   [NREG];
    logic             err_set;
    logic             err_q;
    logic             stall;

    always_comb begin
        int   sum;
        logic inc;
        err_set = 1'b0;
        for (int unsigned r = 0; r < NREG; r++) begin
            dec_n[r] = '0;
            for (int unsigned k = 0; k < NUM_CLR; k++) begin
                if (r != 0 && clr_valid_i[k] && clr_addr_i[k*REG_AW +: REG_AW] == REG_AW'(r))
                    dec_n[r] = dec_n[r] + 3'd1;
            end
            inc = (r != 0) && iss_ack_i && iss_dst_tgt_i && iss_is_load_i
                  && iss_dst_addr_i == REG_AW'(r);
            // Signed sum so over- and under-run are both visible before clamping.
            sum = int'(cnt_q[r]) + int'(inc) - int'(dec_n[r]);
            if (sum < 0) begin
                cnt_nxt[r] = '0;
                err_set    = 1'b1;
            end else if (sum > int'(CNT_MAX)) begin
                cnt_nxt[r] = CNT_W'(CNT_MAX);
                err_set    = 1'b1;
            end else begin
                cnt_nxt[r] = CNT_W'(sum);
            end
`ifdef ID_SCOREBOARD_CLR_BYPASS_EN
            if (flush_i || int'(cnt_q[r]) <= int'(dec_n[r]))
                cnt_chk[r] = '0;
            else
                cnt_chk[r] = cnt_q[r] - CNT_W'(dec_n[r]);
`else
            cnt_chk[r] = cnt_q[r];
`endif
        end
    end

    always_comb begin
        stall = 1'b0;
        for (int unsigned k = 0; k < NUM_SRC; k++) begin
            if (iss_src_rd_i[k] && iss_src_addr_i[k*REG_AW +: REG_AW] != '0
                && cnt_chk[iss_src_addr_i[k*REG_AW +: REG_AW]] != '0)
                stall = 1'b1;
        end
        if (iss_dst_tgt_i && iss_dst_addr_i != '0) begin
            if (!iss_is_load_i && cnt_chk[iss_dst_addr_i] != '0)
                stall = 1'b1;
            else if (iss_is_load_i && cnt_chk[iss_dst_addr_i] == CNT_W'(CNT_MAX))
                stall = 1'b1;
        end
        stall_o = iss_dav_i & stall;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned r = 0; r < NREG; r++)
                cnt_q[r] <= '0;
            err_q <= 1'b0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                for (int unsigned r = 0; r < NREG; r++)
                    cnt_q[r] <= '0;
            end else begin
                for (int unsigned r = 0; r < NREG; r++)
                    cnt_q[r] <= cnt_nxt[r];
                err_q <= err_q | err_set;
            end
        end
    end

    always_comb begin
        pend_vec_o = '0;
        for (int unsigned r = 1; r < NREG; r++)
            pend_vec_o[r-1] = |cnt_q[r];
    end

    assign busy_o = |pend_vec_o;
    assign err_o  = err_q;

endmodule

// File: tb/tb_id_scoreboard.sv
// Bench for id_scoreboard: directed vector table, hand sequences, then random traffic
// checked against an array-based counter model.
module tb_id_scoreboard;

`ifdef ID_SCOREBOARD_CLR_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_i, clk_en, dav, ack, tgt, ld, flush;
    logic [1:0]  src_rd, clr_v;
    logic [9:0]  src_a, clr_a;
    logic [4:0]  dst;
    logic        stall, busy, err;
    logic [30:0] pend;

    int n_cmp = 0;
    int n_bad = 0;
    int m [32];
    bit merr;

    id_scoreboard #(.NUM_SRC(2), .NUM_CLR(2), .CNT_W(2), .REG_AW(5)) dut (
        .clk_i(clk), .reset_i(reset_i), .clk_en_i(clk_en),
        .iss_dav_i(dav), .iss_ack_i(ack), .iss_src_rd_i(src_rd), .iss_src_addr_i(src_a),
        .iss_dst_tgt_i(tgt), .iss_dst_addr_i(dst), .iss_is_load_i(ld),
        .clr_valid_i(clr_v), .clr_addr_i(clr_a), .flush_i(flush),
        .stall_o(stall), .busy_o(busy), .pend_vec_o(pend), .err_o(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit dav, ack;
        int s0;
        bit tgt;
        int dst;
        bit ld;
        int c0, c1;
        bit fl;
        bit es, eb;
        logic [30:0] ep;
        bit ee;
    } vec_t;

    vec_t tbl [23];

    function automatic vec_t v(bit dv, bit ak, int s0, bit tg, int d, bit l, int c0, int c1,
                               bit fl, bit es, bit eb, logic [30:0] ep, bit ee);
        vec_t r;
        r.dav = dv; r.ack = ak; r.s0 = s0; r.tgt = tg; r.dst = d; r.ld = l;
        r.c0 = c0; r.c1 = c1; r.fl = fl; r.es = es; r.eb = eb; r.ep = ep; r.ee = ee;
        return r;
    endfunction

    function automatic logic [30:0] P(int r);
        logic [30:0] one = 31'd1;
        return one << (r - 1);
    endfunction

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    function automatic int n_clr(int a);
        int n = 0;
        for (int k = 0; k < 2; k++)
            if (clr_v[k] && a != 0 && int'(clr_a[k*5 +: 5]) == a) n++;
        return n;
    endfunction

    function automatic int eff(int a);
        int e;
        if (!BYP) return m[a];
        if (flush) return 0;
        e = m[a] - n_clr(a);
        return (e < 0) ? 0 : e;
    endfunction

    function automatic bit model_stall();
        if (!dav) return 1'b0;
        for (int k = 0; k < 2; k++)
            if (src_rd[k] && src_a[k*5 +: 5] != 5'd0 && eff(int'(src_a[k*5 +: 5])) != 0) return 1'b1;
        if (tgt && dst != 5'd0) begin
            if (!ld && eff(int'(dst)) != 0) return 1'b1;
            if (ld && eff(int'(dst)) == 3) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic model_step();
        int t [32];
        if (!clk_en) return;
        if (flush) begin
            for (int r = 0; r < 32; r++) m[r] = 0;
            return;
        end
        t = m;
        if (ack && tgt && ld && dst != 5'd0) t[dst]++;
        for (int k = 0; k < 2; k++)
            if (clr_v[k] && clr_a[k*5 +: 5] != 5'd0) t[clr_a[k*5 +: 5]]--;
        for (int r = 1; r < 32; r++) begin
            if (t[r] < 0) begin t[r] = 0; merr = 1'b1; end
            if (t[r] > 3) begin t[r] = 3; merr = 1'b1; end
        end
        m = t;
    endtask

    function automatic logic [30:0] model_pend();
        logic [30:0] p = '0;
        for (int r = 1; r < 32; r++) p[r-1] = (m[r] != 0);
        return p;
    endfunction

    task automatic idle_inputs();
        dav = 0; ack = 0; tgt = 0; ld = 0; flush = 0; dst = '0;
        src_rd = '0; src_a = '0; clr_v = '0; clr_a = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset_i = 1'b1;
        #3;
        reset_i = 1'b0;
        for (int r = 0; r < 32; r++) m[r] = 0;
        merr = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1; clk_en = 1'b1;
        idle_inputs();
        #12 reset_i = 1'b0;
        chk("reset_stall", {31'd0, stall}, 0);
        chk("reset_busy", {31'd0, busy}, 0);
        chk("reset_pend", {1'b0, pend}, 0);
        chk("reset_err", {31'd0, err}, 0);
        @(posedge clk); #1;

        tbl[0]  = v(0,0,-1,0,0,0,-1,-1,0, 0,0,0,0);
        tbl[1]  = v(1,1,-1,1,5,1,-1,-1,0, 0,1,P(5),0);
        tbl[2]  = v(1,0, 5,0,0,0,-1,-1,0, 1,1,P(5),0);
        tbl[3]  = v(1,0, 5,0,0,0, 5,-1,0, !BYP,0,0,0);
        tbl[4]  = v(1,0, 5,0,0,0,-1,-1,0, 0,0,0,0);
        tbl[5]  = v(1,1,-1,1,7,1,-1,-1,0, 0,1,P(7),0);
        tbl[6]  = v(1,1,-1,1,7,1,-1,-1,0, 0,1,P(7),0);
        tbl[7]  = v(1,1,-1,1,7,1,-1,-1,0, 0,1,P(7),0);
        tbl[8]  = v(1,0,-1,1,7,1,-1,-1,0, 1,1,P(7),0);
        tbl[9]  = v(1,0,-1,1,7,0,-1,-1,0, 1,1,P(7),0);
        tbl[10] = v(0,0,-1,0,0,0, 7,-1,0, 0,1,P(7),0);
        tbl[11] = v(0,0,-1,0,0,0, 7, 7,0, 0,0,0,0);
        tbl[12] = v(1,1,-1,1,9,1,-1,-1,0, 0,1,P(9),0);
        tbl[13] = v(1,1,-1,1,9,1, 9,-1,0, 0,1,P(9),0);
        tbl[14] = v(1,1,-1,1,9,1,-1,-1,0, 0,1,P(9),0);
        tbl[15] = v(0,0,-1,0,0,0, 9, 9,0, 0,0,0,0);
        tbl[16] = v(0,0,-1,0,0,0, 3,-1,0, 0,0,0,1);
        tbl[17] = v(1,0, 0,1,0,0,-1,-1,0, 0,0,0,1);
        tbl[18] = v(1,1,-1,1,0,1,-1,-1,0, 0,0,0,1);
        tbl[19] = v(1,1,-1,1,1,1,-1,-1,0, 0,1,P(1),1);
        tbl[20] = v(1,1, 1,1,2,1,-1,-1,0, 1,1,P(1)|P(2),1);
        tbl[21] = v(1,1,-1,1,3,1,-1,-1,1, 0,0,0,1);
        tbl[22] = v(0,0,-1,0,0,0,-1,-1,0, 0,0,0,1);
        // Row 20 reads x1 (pending) while issuing a load; the ack models an accepted instruction anyway.
        tbl[20].ack = 1'b1;

        for (int i = 0; i < 23; i++) begin
            idle_inputs();
            dav = tbl[i].dav; ack = tbl[i].ack; tgt = tbl[i].tgt; ld = tbl[i].ld;
            dst = 5'(tbl[i].dst); flush = tbl[i].fl;
            if (tbl[i].s0 >= 0) begin src_rd = 2'b01; src_a = {5'd0, 5'(tbl[i].s0)}; end
            if (tbl[i].c0 >= 0) begin clr_v[0] = 1'b1; clr_a[4:0] = 5'(tbl[i].c0); end
            if (tbl[i].c1 >= 0) begin clr_v[1] = 1'b1; clr_a[9:5] = 5'(tbl[i].c1); end
            #1;
            chk($sformatf("tbl%0d_stall", i), {31'd0, stall}, {31'd0, tbl[i].es});
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].eb});
            chk($sformatf("tbl%0d_pend", i), {1'b0, pend}, {1'b0, tbl[i].ep});
            chk($sformatf("tbl%0d_err", i), {31'd0, err}, {31'd0, tbl[i].ee});
        end

        // Clock-enable hold, then asynchronous reset while disabled.
        idle_inputs();
        dav = 1; ack = 1; tgt = 1; ld = 1; dst = 5'd6; clk_en = 1'b0;
        @(posedge clk); #1;
        chk("cen_hold_pend", {1'b0, pend}, 0);
        clk_en = 1'b1;
        @(posedge clk); #1;
        chk("cen_run_pend", {1'b0, pend}, {1'b0, P(6)});
        idle_inputs();
        clk_en = 1'b0;
        #2 reset_i = 1'b1;
        #1;
        chk("async_rst_pend", {1'b0, pend}, 0);
        chk("async_rst_busy", {31'd0, busy}, 0);
        chk("async_rst_err", {31'd0, err}, 0);
        reset_i = 1'b0;
        clk_en = 1'b1;
        @(posedge clk); #1;

        for (int round = 0; round < 4; round++) begin
            do_reset();
            @(posedge clk); #1;
            for (int c = 0; c < 150; c++) begin
                bit es;
                dav = ($urandom % 4) != 0;
                src_rd = 2'($urandom);
                src_a = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
                tgt = $urandom % 2;
                dst = 5'($urandom_range(0, 7));
                ld = ($urandom % 4) != 0;
                for (int k = 0; k < 2; k++) begin
                    int a = $urandom_range(1, 7);
                    clr_v[k] = ($urandom % 3) == 0;
                    if (m[a] == 0 && ($urandom % 16) != 0) clr_v[k] = 1'b0;
                    clr_a[k*5 +: 5] = 5'(a);
                end
                flush = ($urandom % 40) == 0;
                clk_en = ($urandom % 10) != 0;
                ack = 1'b0;
                es = model_stall();
                ack = dav && !es && ($urandom % 2);
                #1;
                chk("rnd_stall", {31'd0, stall}, {31'd0, es});
                model_step();
                @(posedge clk); #1;
                chk("rnd_pend", {1'b0, pend}, {1'b0, model_pend()});
                chk("rnd_busy", {31'd0, busy}, {31'd0, model_pend() != '0});
                chk("rnd_err", {31'd0, err}, {31'd0, merr});
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
